fifo_rd_packer: RTL

Read-side consumer of the async FIFO, clocked in the read domain. It drains bytes from the FIFO read port whenever data is available and packs PACK consecutive entries into one wide word. Words leave through a valid/ready stream toward the downstream datapath. A flush input forces out a partial word, so traffic can be closed cleanly at end of test or end of packet.

---
 rtl/fifo_rd_packer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
//   Read-domain consumer of the async FIFO. Drains FIFO entries whenever data
//   is available and packs PACK consecutive entries into one wide word, which
//   leaves through a valid/ready stream. A flush request forces out the
//   pending partial word (unused lanes zero) and pulses flush_done.
//
// Ports
//   rd_clk        read-domain clock, all logic on posedge
//   rstn          asynchronous active-low reset
//   fifo_empty    FIFO empty flag
//   fifo_rd_data  FIFO read data, valid one cycle after fifo_rd_en
//   fifo_rd_en    FIFO read enable (combinational, never high while empty)
//   out_valid     output word valid
//   out_ready     downstream accepts word
//   out_data      packed word, entry 0 in bits [DATA_WIDTH-1:0]
//   out_bytes     number of valid entries in out_data
//   flush         single-cycle request to emit the pending partial word
//   flush_done    one-cycle pulse when the flush completes
//   word_count    count of accepted output words, wraps
module fifo_rd_packer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PACK       = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                         rd_clk,
    input  logic                         rstn,
    input  logic                         fifo_empty,
    input  logic [DATA_WIDTH-1:0]        fifo_rd_data,
    output logic                         fifo_rd_en,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH*PACK-1:0]   out_data,
    output logic [$clog2(PACK+1)-1:0]    out_bytes,
    input  logic                         flush,
    output logic                         flush_done,
    output logic [CNT_WIDTH-1:0]         word_count
);

    localparam int unsigned BW = $clog2(PACK + 1);
    localparam int unsigned WW = DATA_WIDTH * PACK;
    localparam logic [BW-1:0] PACK_B = BW'(PACK);

    typedef enum logic [1:0] {
        FILL,
        DRAIN,
        EMIT
    } state_e;

    state_e          state_q, state_d;
    logic [WW-1:0]   coll_q, coll_d;
    logic [BW-1:0]   fill_cnt_q, fill_cnt_d;
    logic            inflight_q, inflight_d;
    logic            out_valid_q, out_valid_d;
    logic [WW-1:0]   out_data_q, out_data_d;
    logic [BW-1:0]   out_bytes_q, out_bytes_d;
    logic            flush_done_q, flush_done_d;
    logic [CNT_WIDTH-1:0] word_count_q, word_count_d;

    logic            out_free;
    logic [BW:0]     pend_sum;

    // Entries already held plus the one in flight must leave room in the
    // collection; reads also stop on the cycle a flush is accepted.
    assign pend_sum   = {1'b0, fill_cnt_q} + {{BW{1'b0}}, inflight_q};
    assign fifo_rd_en = rstn && (state_q == FILL) && !flush && !fifo_empty
                        && (pend_sum < {1'b0, PACK_B});

    assign out_free = !out_valid_q || out_ready;

    always_comb begin
        state_d      = state_q;
        coll_d       = coll_q;
        fill_cnt_d   = fill_cnt_q;
        inflight_d   = fifo_rd_en;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_bytes_d  = out_bytes_q;
        flush_done_d = 1'b0;
        word_count_d = word_count_q;

        if (out_valid_q && out_ready) begin
            word_count_d = word_count_q + CNT_WIDTH'(1);
            out_valid_d  = 1'b0;
        end

        if (inflight_q) begin
            for (int unsigned i = 0; i < PACK; i++) begin
                if (fill_cnt_q == BW'(i)) begin
                    coll_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data;
                end
            end
            fill_cnt_d = fill_cnt_q + BW'(1);
        end

        unique case (state_q)
            FILL, DRAIN: begin
                // A word completed by this cycle's capture (or held full from an
                // earlier stall) moves out as soon as the output register frees.
                if (fill_cnt_d == PACK_B && out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = coll_d;
                    out_bytes_d = PACK_B;
                    coll_d      = '0;
                    fill_cnt_d  = '0;
                end
                if (state_q == FILL) begin
                    if (flush) begin
                        state_d = DRAIN;
                    end
                end else if (!inflight_q) begin
                    // Decide on the count left after any full-word move above.
                    if (fill_cnt_d == '0) begin
                        state_d      = FILL;
                        flush_done_d = 1'b1;
                    end else begin
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (out_free) begin
                    out_valid_d  = 1'b1;
                    out_data_d   = coll_q;
                    out_bytes_d  = fill_cnt_q;
                    coll_d       = '0;
                    fill_cnt_d   = '0;
                    flush_done_d = 1'b1;
                    state_d      = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge rd_clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= FILL;
            coll_q       <= '0;
            fill_cnt_q   <= '0;
            inflight_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_bytes_q  <= '0;
            flush_done_q <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            coll_q       <= coll_d;
            fill_cnt_q   <= fill_cnt_d;
            inflight_q   <= inflight_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_bytes_q  <= out_bytes_d;
            flush_done_q <= flush_done_d;
            word_count_q <= word_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_bytes  = out_bytes_q;
    assign flush_done = flush_done_q;
    assign word_count = word_count_q;

endmodule
